game_logic: RTL and testbench

- Game-state controller for the Stickman Run top level.
- Consumes the background block's terrain and coin outputs (frame_counter, GroundY, CoinFrameX, CoinY) and the stickman's vertical position.
- Produces what the background block consumes: CoinStatus, level_status and a one-cycle restart pulse. Also produces score, lives and a state code for the color mapper and HUD.
- Detects coin pickup, pitfall death, level completion, game over and win.

---
 rtl/game_logic.sv | 216 +++++++++++++++++++++
 tb/tb_game_logic.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_logic.sv
// Game-state controller for Stickman Run.
// Synchronises the frame clock and start key, then on each frame tick
// decides coin pickups, pit deaths, level completion, game over and win.
// All outputs come straight from registers.
module game_logic #(
  parameter int STICK_X     = 120,
  parameter int COIN_DX     = 15,
  parameter int COIN_DY     = 30,
  parameter int DEATH_Y     = 470,
  parameter int LEVEL_END   = 3000,
  parameter int DEAD_FRAMES = 60,
  parameter int START_LIVES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start_key,
  input  logic [9:0]  StickY,
  input  logic [11:0] frame_counter,
  input  logic [9:0]  GroundY,
  input  logic [12:0] CoinFrameX [3],
  input  logic [9:0]  CoinY [3],
  output logic [2:0]  CoinStatus,
  output logic [1:0]  level_status,
  output logic        restart,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [2:0]  game_state
);

  typedef enum logic [2:0] {
    ST_START       = 3'd0,
    ST_PLAY        = 3'd1,
    ST_DEAD        = 3'd2,
    ST_LEVEL_CLEAR = 3'd3,
    ST_GAME_OVER   = 3'd4,
    ST_WIN         = 3'd5
  } state_t;

  localparam logic [1:0] LEVEL_1 = 2'b01;
  localparam logic [1:0] LEVEL_2 = 2'b10;

  // GroundY is carried for the HUD/debug only; pit death is judged from StickY.
  logic unused_ground;
  assign unused_ground = ^GroundY;

  // Synchroniser / edge-detect registers
  logic frame_s1_q, frame_s2_q, tick_q;
  logic key_s1_q, key_s2_q, key_s3_q, key_pulse_q;

  // Game registers and their next-state values
  state_t      state_q, state_d;
  logic [2:0]  coins_q, coins_d;
  logic [1:0]  level_q, level_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [5:0]  dead_cnt_q, dead_cnt_d;
  logic        restart_q, restart_d;

  // Per-coin hit detection
  logic [2:0]  hit;
  logic [1:0]  hit_cnt;
  logic [8:0]  score_sum;
  logic [7:0]  score_sat;
  logic        is_dying;
  logic        at_level_end;
  logic        enter_play;

  // Frame clock: two flops then a registered rising-edge pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_s1_q <= 1'b0;
      frame_s2_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      frame_s1_q <= frame_clk;
      frame_s2_q <= frame_s1_q;
      tick_q     <= frame_s1_q & ~frame_s2_q;
    end
  end

  // Start key: two-flop synchroniser, then registered rising-edge pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      key_s3_q    <= 1'b0;
      key_pulse_q <= 1'b0;
    end else begin
      key_s1_q    <= start_key;
      key_s2_q    <= key_s1_q;
      key_s3_q    <= key_s2_q;
      key_pulse_q <= key_s2_q & ~key_s3_q;
    end
  end

  // Coin proximity: 14-bit signed differences, absolute value against the window
  for (genvar gi = 0; gi < 3; gi++) begin : g_coin
    logic [13:0] dx, dy, adx, ady;
    assign dx  = 14'(frame_counter) + 14'(STICK_X) - 14'(CoinFrameX[gi]);
    assign dy  = 14'(StickY) - 14'(CoinY[gi]);
    assign adx = dx[13] ? (14'd0 - dx) : dx;
    assign ady = dy[13] ? (14'd0 - dy) : dy;
    assign hit[gi] = coins_q[gi] && (adx <= 14'(COIN_DX)) && (ady <= 14'(COIN_DY));
  end

  assign hit_cnt      = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
  assign score_sum    = {1'b0, score_q} + {7'd0, hit_cnt};
  assign score_sat    = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign is_dying     = (StickY >= 10'(DEATH_Y));
  assign at_level_end = (frame_counter >= 12'(LEVEL_END));

  // Next-state and datapath decisions for the game FSM
  always_comb begin
    state_d    = state_q;
    coins_d    = coins_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    dead_cnt_d = dead_cnt_q;

    case (state_q)
      ST_START: begin
        if (key_pulse_q) begin
          state_d = ST_PLAY;
          level_d = LEVEL_1;
          score_d = 8'd0;
          lives_d = 2'(START_LIVES);
        end
      end

      ST_PLAY: begin
        if (tick_q) begin
          if (is_dying) begin
            // Death wins over coins on the same frame
            state_d    = ST_DEAD;
            lives_d    = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            dead_cnt_d = 6'd0;
          end else begin
            coins_d = coins_q & ~hit;
            score_d = score_sat;
            if (at_level_end) begin
              state_d = (level_q == LEVEL_2) ? ST_WIN : ST_LEVEL_CLEAR;
            end
          end
        end
      end

      ST_DEAD: begin
        if (tick_q) begin
          if (dead_cnt_q == 6'(DEAD_FRAMES - 1)) begin
            state_d = (lives_q != 2'd0) ? ST_PLAY : ST_GAME_OVER;
          end else begin
            dead_cnt_d = dead_cnt_q + 6'd1;
          end
        end
      end

      ST_LEVEL_CLEAR: begin
        if (key_pulse_q) begin
          state_d = ST_PLAY;
          level_d = LEVEL_2;
        end
      end

      ST_GAME_OVER, ST_WIN: begin
        if (key_pulse_q) begin
          state_d = ST_START;
          level_d = LEVEL_1;
          score_d = 8'd0;
          lives_d = 2'(START_LIVES);
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase

    // Every entry into PLAY restarts the scroll and puts all coins back
    enter_play = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    restart_d  = enter_play;
    if (enter_play) begin
      coins_d = 3'b111;
    end
  end

  // Game state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_START;
      coins_q    <= 3'b111;
      level_q    <= LEVEL_1;
      score_q    <= 8'd0;
      lives_q    <= 2'(START_LIVES);
      dead_cnt_q <= 6'd0;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      coins_q    <= coins_d;
      level_q    <= level_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      dead_cnt_q <= dead_cnt_d;
      restart_q  <= restart_d;
    end
  end

  assign CoinStatus   = coins_q;
  assign level_status = level_q;
  assign restart      = restart_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign game_state   = state_q;

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic with a rule-level reference model.
module tb_game_logic;

  localparam int S_START = 0, S_PLAY = 1, S_DEAD = 2, S_CLEAR = 3, S_OVER = 4, S_WIN = 5;

  logic        Clk, Reset, frame_clk, start_key;
  logic [9:0]  StickY;
  logic [11:0] frame_counter;
  logic [9:0]  GroundY;
  logic [12:0] cfx [3];
  logic [9:0]  cy [3];
  logic [2:0]  CoinStatus;
  logic [1:0]  level_status;
  logic        restart;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic [2:0]  game_state;

  game_logic dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .StickY(StickY), .frame_counter(frame_counter), .GroundY(GroundY),
    .CoinFrameX(cfx), .CoinY(cy),
    .CoinStatus(CoinStatus), .level_status(level_status), .restart(restart),
    .score(score), .lives(lives), .game_state(game_state)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Reference model state
  int m_state, m_coins, m_level, m_score, m_lives, m_dead_ticks, m_restarts;
  int n_checks = 0, n_pass = 0;
  int rise_cnt = 0, hi_cnt = 0;
  logic restart_prev = 1'b0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = S_START; m_coins = 7; m_level = 1; m_score = 0; m_lives = 3; m_dead_ticks = 0;
  endtask

  task automatic model_key();
    case (m_state)
      S_START: begin
        m_state = S_PLAY; m_level = 1; m_score = 0; m_lives = 3; m_coins = 7; m_restarts++;
      end
      S_CLEAR: begin
        m_state = S_PLAY; m_level = 2; m_coins = 7; m_restarts++;
      end
      S_OVER, S_WIN: begin
        m_state = S_START; m_level = 1; m_score = 0; m_lives = 3;
      end
      default: ;
    endcase
  endtask

  task automatic model_tick();
    int dx, dy;
    if (m_state == S_PLAY) begin
      if (int'(StickY) >= 470) begin
        m_state = S_DEAD;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_dead_ticks = 0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          dx = int'(frame_counter) + 120 - int'(cfx[i]);
          dy = int'(StickY) - int'(cy[i]);
          if (dx < 0) dx = -dx;
          if (dy < 0) dy = -dy;
          if (((m_coins >> i) & 1) == 1 && dx <= 15 && dy <= 30) begin
            m_coins = m_coins & ~(1 << i);
            m_score = (m_score < 255) ? m_score + 1 : 255;
          end
        end
        if (int'(frame_counter) >= 3000) m_state = (m_level == 1) ? S_CLEAR : S_WIN;
      end
    end else if (m_state == S_DEAD) begin
      m_dead_ticks++;
      if (m_dead_ticks == 60) begin
        if (m_lives > 0) begin
          m_state = S_PLAY; m_coins = 7; m_restarts++;
        end else begin
          m_state = S_OVER;
        end
      end
    end
  endtask

  // Restart pulse monitor: rising edges and high cycles must both match the model
  always @(negedge Clk) begin
    if (restart) begin
      hi_cnt <= hi_cnt + 1;
      if (!restart_prev) rise_cnt <= rise_cnt + 1;
    end
    restart_prev <= restart;
  end

  // Cycle-by-cycle comparison against the model whenever the DUT has settled
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("game_state", int'(game_state), m_state);
      chk("CoinStatus", int'(CoinStatus), m_coins);
      chk("level_status", int'(level_status), m_level);
      chk("score", int'(score), m_score);
      chk("lives", int'(lives), m_lives);
      chk("restart_idle", int'(restart), 0);
      chk("restart_rises", rise_cnt, m_restarts);
      chk("restart_cycles", hi_cnt, m_restarts);
    end
  end

  task automatic do_tick();
    chk_en = 1'b0;
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    model_tick();
    $display("tick fc=%0d y=%0d -> state=%0d coins=%b score=%0d lives=%0d",
             frame_counter, StickY, game_state, CoinStatus, score, lives);
    chk_en = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic press_key(input int hold);
    chk_en = 1'b0;
    start_key = 1'b1;
    repeat (hold) @(negedge Clk);
    start_key = 1'b0;
    repeat (4) @(negedge Clk);
    model_key();
    $display("key hold=%0d -> state=%0d level=%b restarts=%0d", hold, game_state, level_status, rise_cnt);
    chk_en = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic set_coin(input int i, input int x, input int y);
    cfx[i] = 13'(x);
    cy[i]  = 10'(y);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(game_state), 0);
    chk({tag, "_coins"}, int'(CoinStatus), 7);
    chk({tag, "_level"}, int'(level_status), 1);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_lives"}, int'(lives), 3);
    chk({tag, "_restart"}, int'(restart), 0);
  endtask

  initial begin
    m_restarts = 0;
    model_reset();
    Reset = 1'b1; frame_clk = 1'b0; start_key = 1'b0;
    StickY = 10'd250; frame_counter = 12'd100; GroundY = 10'd400;
    set_coin(0, 1000, 240); set_coin(1, 2000, 240); set_coin(2, 2500, 240);
    repeat (3) @(negedge Clk);
    chk_reset_vals("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    repeat (2) @(negedge Clk);

    // Held key gives exactly one restart
    press_key(100);
    chk("start_state", int'(game_state), 1);
    chk("start_restarts", rise_cnt, 1);
    chk("start_lives", int'(lives), 3);

    // Single coin pickup, then no double count
    frame_counter = 12'd550; set_coin(0, 670, 240); StickY = 10'd250;
    do_tick();
    chk("coin0_status", int'(CoinStatus), 6);
    chk("coin0_score", int'(score), 1);
    do_tick();
    chk("coin0_again", int'(score), 1);

    // Window edges: coin1 at dx=-15,dy=-30 taken; coin2 at dx=-16 not
    set_coin(1, 685, 280); set_coin(2, 686, 250);
    do_tick();
    chk("edge_status", int'(CoinStatus), 4);
    chk("edge_score", int'(score), 2);

    // Death beats a coin in range
    StickY = 10'd475; set_coin(2, 670, 470);
    do_tick();
    chk("death_state", int'(game_state), 2);
    chk("death_lives", int'(lives), 2);
    chk("death_coins", int'(CoinStatus), 4);
    press_key(100);
    chk("dead_ignores_key", int'(game_state), 2);
    ticks(59);
    chk("dead_59", int'(game_state), 2);
    do_tick();
    chk("respawn_state", int'(game_state), 1);
    chk("respawn_coins", int'(CoinStatus), 7);
    chk("respawn_restarts", rise_cnt, 2);

    // Two coins on one tick
    StickY = 10'd250; set_coin(0, 670, 240); set_coin(1, 672, 245); set_coin(2, 2500, 240);
    do_tick();
    chk("multi_score", int'(score), 4);
    chk("multi_coins", int'(CoinStatus), 4);

    // Lose remaining lives
    StickY = 10'd475;
    do_tick();
    ticks(60);
    do_tick();
    chk("last_death_lives", int'(lives), 0);
    ticks(60);
    chk("gameover_state", int'(game_state), 4);
    chk("gameover_restarts", rise_cnt, 3);
    press_key(100);
    chk("over_to_start", int'(game_state), 0);
    chk("over_lives", int'(lives), 3);
    chk("over_score", int'(score), 0);

    // Level 1 clear, level 2 win
    StickY = 10'd250;
    press_key(100);
    frame_counter = 12'd3000; set_coin(0, 3120, 250);
    do_tick();
    chk("clear_state", int'(game_state), 3);
    chk("clear_score", int'(score), 1);
    press_key(100);
    chk("lvl2_level", int'(level_status), 2);
    chk("lvl2_restarts", rise_cnt, 5);
    frame_counter = 12'd2999;
    do_tick();
    chk("lvl2_2999", int'(game_state), 1);
    chk("lvl2_score", int'(score), 2);
    frame_counter = 12'd3000;
    do_tick();
    chk("win_state", int'(game_state), 5);
    press_key(100);
    chk("win_to_start", int'(game_state), 0);

    // Async reset mid-DEAD
    press_key(100);
    StickY = 10'd475;
    do_tick();
    ticks(5);
    chk("pre_reset_dead", int'(game_state), 2);
    chk_en = 1'b0;
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1 chk_reset_vals("async");
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    StickY = 10'd250;
    chk_en = 1'b1;
    ticks(3);
    chk("idle_start", int'(game_state), 0);
    chk("final_restarts", rise_cnt, 6);

    chk_en = 1'b0;
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
